// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants for the single-master crossbar.
// Opcodes, default field widths and a small index-width helper.
package tl_ul_pkg;

  localparam int DEF_ADDR_WIDTH   = 64;
  localparam int DEF_DATA_WIDTH   = 64;
  localparam int DEF_SOURCE_WIDTH = 3;
  localparam int DEF_SINK_WIDTH   = 3;
  localparam int DEF_OPCODE_WIDTH = 3;
  localparam int DEF_PARAM_WIDTH  = 3;
  localparam int DEF_SIZE_WIDTH   = 8;

  localparam logic [2:0] PUT_FULL_DATA_A    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL_DATA_A = 3'd1;
  localparam logic [2:0] GET_A              = 3'd4;

  localparam logic [2:0] ACCESS_ACK_D      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA_D = 3'd1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter with one-hot grant.
// The pointer moves past the winner only when en is high.
module tl_rr_arbiter
  import tl_ul_pkg::*;
#(
  parameter int N = 5,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          hit;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req[(int'(ptr) + k) % N]) begin
        hit = 1'b1;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && hit) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/tilelink_ul_xbar_1m_ns.sv
// TileLink-UL crossbar: one master, NUM_SLAVES slaves, internal error
// responder for unmapped addresses and a registered round-robin D port.
module tilelink_ul_xbar_1m_ns
  import tl_ul_pkg::*;
#(
  parameter int TL_ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int TL_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int TL_SOURCE_WIDTH = DEF_SOURCE_WIDTH,
  parameter int TL_SINK_WIDTH   = DEF_SINK_WIDTH,
  parameter int TL_OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int TL_PARAM_WIDTH  = DEF_PARAM_WIDTH,
  parameter int TL_SIZE_WIDTH   = DEF_SIZE_WIDTH,
  parameter int NUM_SLAVES      = 4,
  parameter logic [TL_ADDR_WIDTH-1:0] MEM_BASE_ADDR = '0,
  parameter int REGION_BYTES    = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,

  input  logic                       m_a_valid,
  output logic                       m_a_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] m_a_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  m_a_param,
  input  logic [TL_ADDR_WIDTH-1:0]   m_a_address,
  input  logic [TL_SIZE_WIDTH-1:0]   m_a_size,
  input  logic [TL_STRB_WIDTH-1:0]   m_a_mask,
  input  logic [TL_DATA_WIDTH-1:0]   m_a_data,
  input  logic [TL_SOURCE_WIDTH-1:0] m_a_source,

  output logic                       m_d_valid,
  input  logic                       m_d_ready,
  output logic [TL_OPCODE_WIDTH-1:0] m_d_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  m_d_param,
  output logic [TL_SIZE_WIDTH-1:0]   m_d_size,
  output logic [TL_DATA_WIDTH-1:0]   m_d_data,
  output logic [TL_SOURCE_WIDTH-1:0] m_d_source,
  output logic [TL_SINK_WIDTH-1:0]   m_d_sink,
  output logic                       m_d_error,

  output logic [NUM_SLAVES-1:0]                 s_a_valid,
  input  logic [NUM_SLAVES-1:0]                 s_a_ready,
  output logic [NUM_SLAVES*TL_OPCODE_WIDTH-1:0] s_a_opcode,
  output logic [NUM_SLAVES*TL_PARAM_WIDTH-1:0]  s_a_param,
  output logic [NUM_SLAVES*TL_ADDR_WIDTH-1:0]   s_a_address,
  output logic [NUM_SLAVES*TL_SIZE_WIDTH-1:0]   s_a_size,
  output logic [NUM_SLAVES*TL_STRB_WIDTH-1:0]   s_a_mask,
  output logic [NUM_SLAVES*TL_DATA_WIDTH-1:0]   s_a_data,
  output logic [NUM_SLAVES*TL_SOURCE_WIDTH-1:0] s_a_source,

  input  logic [NUM_SLAVES-1:0]                 s_d_valid,
  output logic [NUM_SLAVES-1:0]                 s_d_ready,
  input  logic [NUM_SLAVES*TL_OPCODE_WIDTH-1:0] s_d_opcode,
  input  logic [NUM_SLAVES*TL_PARAM_WIDTH-1:0]  s_d_param,
  input  logic [NUM_SLAVES*TL_SIZE_WIDTH-1:0]   s_d_size,
  input  logic [NUM_SLAVES*TL_DATA_WIDTH-1:0]   s_d_data,
  input  logic [NUM_SLAVES*TL_SOURCE_WIDTH-1:0] s_d_source,
  input  logic [NUM_SLAVES*TL_SINK_WIDTH-1:0]   s_d_sink,
  input  logic [NUM_SLAVES-1:0]                 s_d_error
);

  localparam int SW  = idx_width(NUM_SLAVES);
  localparam int NR  = NUM_SLAVES + 1;
  localparam int RW  = idx_width(NR);
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int RSH = $clog2(REGION_BYTES);

  logic [TL_ADDR_WIDTH-1:0] off;
  logic [TL_ADDR_WIDTH-1:0] rix;
  logic [SW-1:0]            sel;
  logic                     mapped;
  logic [CW-1:0]            cnt;
  logic                     full;
  logic                     a_fire;
  logic                     d_fire;

  logic                       err_busy;
  logic                       err_get;
  logic [TL_SIZE_WIDTH-1:0]   err_size;
  logic [TL_SOURCE_WIDTH-1:0] err_src;

  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [RW-1:0] widx;
  logic [SW-1:0] wsl;
  logic          slot_free;

  logic [TL_OPCODE_WIDTH-1:0] w_op;
  logic [TL_PARAM_WIDTH-1:0]  w_param;
  logic [TL_SIZE_WIDTH-1:0]   w_size;
  logic [TL_DATA_WIDTH-1:0]   w_data;
  logic [TL_SOURCE_WIDTH-1:0] w_src;
  logic [TL_SINK_WIDTH-1:0]   w_sink;
  logic                       w_err;

  assign off    = m_a_address - MEM_BASE_ADDR;
  assign rix    = off >> RSH;
  assign sel    = rix[SW-1:0];
  assign mapped = (m_a_address >= MEM_BASE_ADDR) &&
                  (rix < TL_ADDR_WIDTH'(NUM_SLAVES));
  assign full   = (cnt == CW'(MAX_OUTSTANDING));

  assign s_a_valid = (m_a_valid && mapped && !full && !rst) ?
                     (NUM_SLAVES'(1) << sel) : '0;
  assign m_a_ready = !rst && !full &&
                     (mapped ? s_a_ready[sel] : !err_busy);
  assign a_fire    = m_a_valid && m_a_ready;
  assign d_fire    = m_d_valid && m_d_ready;

  assign s_a_opcode  = {NUM_SLAVES{m_a_opcode}};
  assign s_a_param   = {NUM_SLAVES{m_a_param}};
  assign s_a_address = {NUM_SLAVES{m_a_address}};
  assign s_a_size    = {NUM_SLAVES{m_a_size}};
  assign s_a_mask    = {NUM_SLAVES{m_a_mask}};
  assign s_a_data    = {NUM_SLAVES{m_a_data}};
  assign s_a_source  = {NUM_SLAVES{m_a_source}};

  assign req       = {err_busy, s_d_valid};
  assign slot_free = !m_d_valid || m_d_ready;
  assign s_d_ready = rst ? '0 :
                     gnt[NUM_SLAVES-1:0] & {NUM_SLAVES{slot_free}};
  assign wsl       = widx[SW-1:0];

  tl_rr_arbiter #(.N(NR)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (slot_free),
    .gnt (gnt),
    .idx (widx)
  );

  // Error responder occupies the last arbitration slot.
  always_comb begin
    w_op    = '0;
    w_param = '0;
    w_size  = '0;
    w_data  = '0;
    w_src   = '0;
    w_sink  = '0;
    w_err   = 1'b0;
    if (int'(widx) == NUM_SLAVES) begin
      w_op   = err_get ? TL_OPCODE_WIDTH'(ACCESS_ACK_DATA_D)
                       : TL_OPCODE_WIDTH'(ACCESS_ACK_D);
      w_size = err_size;
      w_src  = err_src;
      w_err  = 1'b1;
    end else begin
      w_op    = s_d_opcode[wsl*TL_OPCODE_WIDTH +: TL_OPCODE_WIDTH];
      w_param = s_d_param[wsl*TL_PARAM_WIDTH +: TL_PARAM_WIDTH];
      w_size  = s_d_size[wsl*TL_SIZE_WIDTH +: TL_SIZE_WIDTH];
      w_data  = s_d_data[wsl*TL_DATA_WIDTH +: TL_DATA_WIDTH];
      w_src   = s_d_source[wsl*TL_SOURCE_WIDTH +: TL_SOURCE_WIDTH];
      w_sink  = s_d_sink[wsl*TL_SINK_WIDTH +: TL_SINK_WIDTH];
      w_err   = s_d_error[wsl];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_busy <= 1'b0;
      err_get  <= 1'b0;
      err_size <= '0;
      err_src  <= '0;
    end else if (a_fire && !mapped) begin
      err_busy <= 1'b1;
      err_get  <= (m_a_opcode == TL_OPCODE_WIDTH'(GET_A));
      err_size <= m_a_size;
      err_src  <= m_a_source;
    end else if (gnt[NUM_SLAVES] && slot_free) begin
      err_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_d_valid  <= 1'b0;
      m_d_opcode <= '0;
      m_d_param  <= '0;
      m_d_size   <= '0;
      m_d_data   <= '0;
      m_d_source <= '0;
      m_d_sink   <= '0;
      m_d_error  <= 1'b0;
    end else if (slot_free) begin
      m_d_valid <= |req;
      if (|req) begin
        m_d_opcode <= w_op;
        m_d_param  <= w_param;
        m_d_size   <= w_size;
        m_d_data   <= w_data;
        m_d_source <= w_src;
        m_d_sink   <= w_sink;
        m_d_error  <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (a_fire && !d_fire) begin
      cnt <= cnt + CW'(1);
    end else if (!a_fire && d_fire) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_tilelink_ul_xbar_1m_ns.sv
// Bench for tilelink_ul_xbar_1m_ns: memory-backed slave models, a
// per-source scoreboard, directed scenarios and a random phase.
module tb_tilelink_ul_xbar_1m_ns;
  import tl_ul_pkg::*;

  localparam int NS   = 4;
  localparam int MAXO = 4;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] data;
    logic        err;
    logic [2:0]  src;
    logic [7:0]  size;
    logic [2:0]  sink;
  } rsp_t;

  logic clk;
  logic rst;
  logic        m_a_valid, m_a_ready;
  logic [2:0]  m_a_opcode, m_a_param, m_a_source;
  logic [63:0] m_a_address, m_a_data;
  logic [7:0]  m_a_size, m_a_mask;
  logic        m_d_valid, m_d_ready, m_d_error;
  logic [2:0]  m_d_opcode, m_d_param, m_d_source, m_d_sink;
  logic [7:0]  m_d_size;
  logic [63:0] m_d_data;
  logic [NS-1:0]    s_a_valid, s_a_ready;
  logic [NS*3-1:0]  s_a_opcode, s_a_param, s_a_source;
  logic [NS*64-1:0] s_a_address, s_a_data;
  logic [NS*8-1:0]  s_a_size, s_a_mask;
  logic [NS-1:0]    s_d_valid, s_d_ready, s_d_error;
  logic [NS*3-1:0]  s_d_opcode, s_d_param, s_d_source, s_d_sink;
  logic [NS*8-1:0]  s_d_size;
  logic [NS*64-1:0] s_d_data;

  tilelink_ul_xbar_1m_ns #(
    .NUM_SLAVES(NS), .MEM_BASE_ADDR(64'd0),
    .REGION_BYTES(512), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param),
    .m_a_address(m_a_address), .m_a_size(m_a_size),
    .m_a_mask(m_a_mask), .m_a_data(m_a_data),
    .m_a_source(m_a_source),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param),
    .m_d_size(m_d_size), .m_d_data(m_d_data),
    .m_d_source(m_d_source), .m_d_sink(m_d_sink),
    .m_d_error(m_d_error),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
    .s_a_address(s_a_address), .s_a_size(s_a_size),
    .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_a_source(s_a_source),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param),
    .s_d_size(s_d_size), .s_d_data(s_d_data),
    .s_d_source(s_d_source), .s_d_sink(s_d_sink),
    .s_d_error(s_d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int outs  = 0;

  logic        req_v;
  logic [2:0]  req_op, req_src;
  logic [63:0] req_addr, req_data;
  logic        mdr;
  logic [NS-1:0] d_en, a_rdy;
  bit          a_fired, last_fire, hold_prev;
  rsp_t        last_rsp, prev_d;

  rsp_t        sq [NS][$];
  rsp_t        exp_r [8];
  bit          pend [8];
  logic [63:0] mem [logic [63:0]];
  rsp_t        dlog [$];
  int          dcyc [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int tgt(input logic [63:0] a);
    if (a / 64'd512 < 64'(NS)) return int'(a / 64'd512);
    return -1;
  endfunction

  task automatic step();
    int t;
    logic [NS-1:0] exp_sav;
    rsp_t r;
    @(negedge clk);
    cyc++;
    m_a_valid = req_v; m_a_opcode = req_op; m_a_param = '0;
    m_a_address = req_addr; m_a_data = req_data;
    m_a_source = req_src; m_a_size = 8'd3; m_a_mask = '1;
    m_d_ready = mdr;
    s_a_ready = a_rdy;
    for (int i = 0; i < NS; i++) begin
      if (d_en[i] && sq[i].size() > 0) begin
        r = sq[i][0];
        s_d_valid[i] = 1'b1;
        s_d_opcode[i*3 +: 3] = r.op;
        s_d_param[i*3 +: 3]  = '0;
        s_d_size[i*8 +: 8]   = r.size;
        s_d_data[i*64 +: 64] = r.data;
        s_d_source[i*3 +: 3] = r.src;
        s_d_sink[i*3 +: 3]   = r.sink;
        s_d_error[i]         = r.err;
      end else begin
        s_d_valid[i] = 1'b0;
      end
    end
    #1;
    t = tgt(req_addr);
    exp_sav = '0;
    if (req_v && t >= 0 && outs < MAXO) exp_sav[t] = 1'b1;
    chk("s_a_valid", s_a_valid, exp_sav);
    if (req_v && outs >= MAXO) chk("a_throttle", m_a_ready, 0);
    if (req_v && t >= 0 && outs < MAXO) begin
      chk("a_ready", m_a_ready, a_rdy[t]);
      chk("s_a_addr", s_a_address[t*64 +: 64], req_addr);
      chk("s_a_src", s_a_source[t*3 +: 3], req_src);
    end
    if (m_d_valid && !mdr) chk("sdr_stall", s_d_ready, 0);
    chk("sdr_sub", s_d_ready & ~s_d_valid, 0);
    chk("sdr_onehot", $countones(s_d_ready) <= 1, 1);
    if (hold_prev) begin
      chk("hold_v", m_d_valid, 1);
      chk("hold_data", m_d_data, prev_d.data);
      chk("hold_src", m_d_source, prev_d.src);
      chk("hold_op", m_d_opcode, prev_d.op);
    end
    r = '0;
    r.op = m_d_opcode; r.data = m_d_data; r.err = m_d_error;
    r.src = m_d_source; r.size = m_d_size; r.sink = m_d_sink;
    hold_prev = m_d_valid && !mdr;
    prev_d = r;
    last_fire = 1'b0;
    if (m_d_valid && mdr) begin
      last_fire = 1'b1;
      last_rsp = r;
      chk("d_pend", pend[r.src], 1);
      if (pend[r.src]) begin
        chk("d_op", r.op, exp_r[r.src].op);
        chk("d_data", r.data, exp_r[r.src].data);
        chk("d_err", r.err, exp_r[r.src].err);
        chk("d_size", r.size, exp_r[r.src].size);
        chk("d_sink", r.sink, exp_r[r.src].sink);
        outs--;
      end
      pend[r.src] = 1'b0;
      dlog.push_back(r);
      dcyc.push_back(cyc);
    end
    for (int i = 0; i < NS; i++)
      if (s_d_valid[i] && s_d_ready[i]) void'(sq[i].pop_front());
    a_fired = req_v && m_a_ready;
    if (a_fired) begin
      r = '0;
      r.src = req_src; r.size = 8'd3;
      if (t >= 0) begin
        r.sink = 3'(t);
        if (req_op == GET_A) begin
          r.op = ACCESS_ACK_DATA_D;
          r.data = mem.exists(req_addr) ? mem[req_addr] : 64'd0;
        end else begin
          r.op = ACCESS_ACK_D;
          mem[req_addr] = req_data;
        end
        sq[t].push_back(r);
      end else begin
        r.err = 1'b1;
        r.op = (req_op == GET_A) ? ACCESS_ACK_DATA_D : ACCESS_ACK_D;
      end
      exp_r[req_src] = r;
      pend[req_src] = 1'b1;
      outs++;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] d, input logic [2:0] s);
    req_v = 1'b1; req_op = op; req_addr = a; req_data = d; req_src = s;
    step();
  endtask

  task automatic wait_src(input logic [2:0] s, input int budget,
                          output rsp_t r);
    bit got;
    got = 1'b0;
    r = '0;
    for (int k = 0; k < budget && !got; k++) begin
      step();
      if (last_fire && last_rsp.src == s) begin
        got = 1'b1;
        r = last_rsp;
      end
    end
    chk("wait_src", got, 1);
  endtask

  task automatic drain();
    req_v = 1'b0; mdr = 1'b1; d_en = '1;
    for (int k = 0; k < 200 && outs > 0; k++) step();
    chk("drain", outs, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_v = 1'b0; m_a_valid = 1'b0; s_d_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NS; i++) sq[i].delete();
    for (int i = 0; i < 8; i++) pend[i] = 1'b0;
    outs = 0;
    hold_prev = 1'b0;
  endtask

  task automatic new_req();
    int k;
    logic [2:0] s;
    do s = 3'($urandom_range(0, 7)); while (pend[s]);
    k = $urandom_range(0, 5);
    req_addr = (k == 5) ? 64'hFFFF_FFFF_0000_0000 : 64'(k * 512);
    req_addr = req_addr + 64'(8 * $urandom_range(0, 3));
    case ($urandom_range(0, 2))
      0: req_op = PUT_FULL_DATA_A;
      1: req_op = PUT_PARTIAL_DATA_A;
      default: req_op = GET_A;
    endcase
    req_data = {$urandom, $urandom};
    req_src = s;
    req_v = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t r;
    logic [2:0] hsrc;
    logic [63:0] hdat;
    int n0;
    rst = 1'b1;
    m_a_valid = 0; m_a_opcode = 0; m_a_param = 0; m_a_address = 0;
    m_a_size = 0; m_a_mask = 0; m_a_data = 0; m_a_source = 0;
    m_d_ready = 0; s_a_ready = 0; s_d_valid = 0; s_d_opcode = 0;
    s_d_param = 0; s_d_size = 0; s_d_data = 0; s_d_source = 0;
    s_d_sink = 0; s_d_error = 0;
    req_v = 0; req_op = 0; req_addr = 0; req_data = 0; req_src = 0;
    mdr = 1; d_en = '0; a_rdy = '1;
    a_fired = 0; last_fire = 0; hold_prev = 0;
    last_rsp = '0; prev_d = '0;
    for (int i = 0; i < 8; i++) begin pend[i] = 0; exp_r[i] = '0; end
    repeat (2) @(posedge clk);
    do_reset();

    step();
    chk("rst_mdv", m_d_valid, 0);
    chk("rst_sdr", s_d_ready, 0);
    chk("rst_ardy", m_a_ready, 1);

    d_en = '1;
    issue(PUT_FULL_DATA_A, 64'd600, 64'h1234_5678_9ABC_DEF0, 3'd0);
    chk("put600_sav", s_a_valid, 4'b0010);
    req_v = 1'b0;
    wait_src(3'd0, 10, r);
    issue(GET_A, 64'd600, 64'd0, 3'd1);
    req_v = 1'b0;
    wait_src(3'd1, 10, r);
    chk("get600_op", r.op, 1);
    chk("get600_data", r.data, 64'h1234_5678_9ABC_DEF0);
    chk("get600_err", r.err, 0);

    issue(GET_A, 64'd2048, 64'd0, 3'd5);
    chk("unm_sav", s_a_valid, 0);
    chk("unm_rdy", m_a_ready, 1);
    req_v = 1'b0;
    wait_src(3'd5, 10, r);
    chk("unm_get_op", r.op, 1);
    chk("unm_get_err", r.err, 1);
    chk("unm_get_data", r.data, 0);
    issue(PUT_FULL_DATA_A, 64'd2100, 64'hDEAD, 3'd6);
    req_v = 1'b0;
    wait_src(3'd6, 10, r);
    chk("unm_put_op", r.op, 0);
    chk("unm_put_err", r.err, 1);

    do_reset();
    d_en = '0; mdr = 1'b1;
    issue(GET_A, 64'd0, 64'd0, 3'd0);
    issue(GET_A, 64'd1024, 64'd0, 3'd2);
    issue(GET_A, 64'd1536, 64'd0, 3'd3);
    req_v = 1'b0;
    d_en = 4'b1101;
    n0 = dlog.size();
    for (int k = 0; k < 10 && dlog.size() < n0 + 3; k++) step();
    chk("ord_cnt", 64'(dlog.size() - n0), 3);
    if (dlog.size() >= n0 + 3) begin
      chk("ord_0", dlog[n0].src, 0);
      chk("ord_1", dlog[n0+1].src, 2);
      chk("ord_2", dlog[n0+2].src, 3);
      chk("ord_c1", 64'(dcyc[n0+1] - dcyc[n0]), 1);
      chk("ord_c2", 64'(dcyc[n0+2] - dcyc[n0+1]), 1);
    end
    drain();

    mdr = 1'b0; d_en = '1;
    issue(GET_A, 64'd512, 64'd0, 3'd1);
    issue(GET_A, 64'd1024, 64'd0, 3'd2);
    req_v = 1'b0;
    for (int k = 0; k < 5 && !m_d_valid; k++) step();
    chk("stall_v", m_d_valid, 1);
    hsrc = m_d_source;
    hdat = m_d_data;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_src", m_d_source, hsrc);
      chk("stall_data", m_d_data, hdat);
      chk("stall_sdr", s_d_ready, 0);
    end
    drain();

    d_en = '0; mdr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(GET_A, 64'(8 * i), 64'd0, 3'(i));
      chk("fill_fire", a_fired, 1);
    end
    req_v = 1'b1; req_op = GET_A; req_addr = 64'd32; req_src = 3'd4;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_rdy", m_a_ready, 0);
    end
    d_en[0] = 1'b1;
    for (int k = 0; k < 6 && !last_fire; k++) begin
      step();
      if (last_fire) chk("dfire_rdy", m_a_ready, 0);
    end
    chk("dfire_seen", last_fire, 1);
    step();
    chk("unblock_rdy", m_a_ready, 1);
    chk("unblock_fire", a_fired, 1);
    drain();

    mdr = 1'b0; d_en = '1;
    issue(GET_A, 64'd512, 64'd0, 3'd1);
    req_v = 1'b0;
    for (int k = 0; k < 5 && !m_d_valid; k++) step();
    chk("held_v", m_d_valid, 1);
    do_reset();
    mdr = 1'b1; a_rdy = '1;
    issue(PUT_FULL_DATA_A, 64'd8, 64'h55AA, 3'd0);
    chk("post_rst_mdv", m_d_valid, 0);
    chk("post_rst_ardy", m_a_ready, 1);
    req_v = 1'b0;
    drain();

    for (int n = 0; n < 3000; n++) begin
      mdr   = ($urandom_range(0, 3) != 0);
      d_en  = NS'($urandom);
      a_rdy = NS'($urandom);
      if (a_fired) req_v = 1'b0;
      if (!req_v && $urandom_range(0, 2) != 0) new_req();
      step();
    end
    if (a_fired) req_v = 1'b0;
    if (req_v) begin
      a_rdy = '1;
      for (int k = 0; k < 50 && !a_fired; k++) step();
      req_v = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
